// File: rtl/lfsr_prpg_if.sv
// LFSR pattern generator bus: control inputs (start/stop/seed load,
// pattern count) and scan outputs (chains, strobes, LFSR contents).
interface lfsr_prpg_if #(
  parameter int WIDTH  = 16,
  parameter int CHAINS = 4
);
  logic              start;
  logic              stop;
  logic              seed_load;
  logic [WIDTH-1:0]  seed;
  logic [15:0]       pattern_count;
  logic [CHAINS-1:0] scan_in;
  logic              scan_en;
  logic              capture;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  lfsr_state;

  modport master (
    output start, stop, seed_load, seed, pattern_count,
    input  scan_in, scan_en, capture, busy, done, lfsr_state
  );

  modport slave (
    input  start, stop, seed_load, seed, pattern_count,
    output scan_in, scan_en, capture, busy, done, lfsr_state
  );
endinterface

// File: rtl/lfsr_prpg.sv
// Fibonacci LFSR pseudo-random pattern generator with SHIFT/CAPTURE FSM.
// Ports: clock, reset (async, active-low), bus (lfsr_prpg_if.slave).
// Option: define LFSR_PRPG_PHASE_SHIFTER_EN to XOR-spread scan_in.
module lfsr_prpg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] POLY      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'h0001,
  parameter int               CHAINS    = 4,
  parameter int               CHAIN_LEN = 8
) (
  input logic        clock,
  input logic        reset,
  lfsr_prpg_if.slave bus
);

  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_nx;
  logic [15:0]       rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              scan_en_q;
  logic              capture_q;
  logic              busy_q;
  logic              done_q;
  logic              run;

  assign lfsr_nx = {lfsr_q[WIDTH-2:0], ^(lfsr_q & POLY)};
  assign run     = (state_q == SHIFT) || (state_q == CAPTURE);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // a zero seed is replaced so the LFSR never locks up
        if (bus.seed_load)
          lfsr_d = (bus.seed == '0) ? SEED : bus.seed;
        if (bus.start && !bus.stop) begin
          if (bus.pattern_count != 16'd0) begin
            rem_d   = bus.pattern_count;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_nx;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? DONE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // abort overrides every transition; LFSR keeps its value
    if (bus.stop && run) begin
      state_d = IDLE;
      lfsr_d  = lfsr_q;
      rem_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      rem_q     <= '0;
      cnt_q     <= '0;
      scan_en_q <= 1'b0;
      capture_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      scan_en_q <= (state_d == SHIFT);
      capture_q <= (state_d == CAPTURE);
      busy_q    <= (state_d == SHIFT) || (state_d == CAPTURE);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.scan_en    = scan_en_q;
  assign bus.capture    = capture_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.lfsr_state = lfsr_q;

  for (genvar i = 0; i < CHAINS; i++) begin : g_chain
`ifdef LFSR_PRPG_PHASE_SHIFTER_EN
    localparam int J = (i + WIDTH / 2) % WIDTH;
    assign bus.scan_in[i] = lfsr_q[i] ^ lfsr_q[J];
`else
    assign bus.scan_in[i] = lfsr_q[i];
`endif
  end

endmodule

// File: tb/tb_lfsr_prpg.sv
// Directed bench for lfsr_prpg (WIDTH=4, POLY=C, SEED=1, CHAINS=2,
// CHAIN_LEN=3) in the default build.
module tb_lfsr_prpg;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   idx;

  logic [3:0] seq [0:14] = '{
    4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8
  };

  lfsr_prpg_if #(.WIDTH(4), .CHAINS(2)) bus ();

  lfsr_prpg #(
    .WIDTH(4), .POLY(4'hC), .SEED(4'h1),
    .CHAINS(2), .CHAIN_LEN(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one run of n patterns; poke drives start/seed_load during SHIFT
  task automatic run(input int n, input bit poke);
    logic [3:0] v;
    bus.start         = 1'b1;
    bus.pattern_count = 16'(n);
    step();
    bus.start = 1'b0;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < 3; k++) begin
        v = seq[idx];
        chk("shift_scan_en", 32'(bus.scan_en), 32'd1);
        chk("shift_busy", 32'(bus.busy), 32'd1);
        chk("shift_lfsr", 32'(bus.lfsr_state), 32'(v));
        chk("shift_scan_in", 32'(bus.scan_in), 32'(v[1:0]));
        if (poke) begin
          bus.start         = 1'b1;
          bus.pattern_count = 16'd0;
          bus.seed_load     = 1'b1;
          bus.seed          = 4'h3;
        end
        idx = (idx + 1) % 15;
        step();
      end
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      chk("cap_pulse", 32'(bus.capture), 32'd1);
      chk("cap_scan_en", 32'(bus.scan_en), 32'd0);
      chk("cap_lfsr", 32'(bus.lfsr_state), 32'(seq[idx]));
      step();
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_lfsr", 32'(bus.lfsr_state), 32'(seq[idx]));
    step();
    chk("done_end", 32'(bus.done), 32'd0);
    chk("idle_lfsr", 32'(bus.lfsr_state), 32'(seq[idx]));
  endtask

  initial begin
    n_cmp             = 0;
    n_bad             = 0;
    idx               = 0;
    reset             = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.seed_load     = 1'b0;
    bus.seed          = '0;
    bus.pattern_count = '0;
    #12;
    chk("rst_lfsr", 32'(bus.lfsr_state), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_scan_en", 32'(bus.scan_en), 32'd0);
    chk("rst_capture", 32'(bus.capture), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_hold", 32'(bus.lfsr_state), 32'h1);

    // full period: 5 patterns x 3 shifts = 15 steps back to 1
    run(5, 1'b0);
    chk("period", 32'(bus.lfsr_state), 32'h1);

    // seed loading
    bus.seed_load = 1'b1;
    bus.seed      = 4'h0;
    step();
    chk("seed_zero", 32'(bus.lfsr_state), 32'h1);
    bus.seed = 4'h9;
    step();
    chk("seed_9", 32'(bus.lfsr_state), 32'h9);
    chk("scan_in_9", 32'(bus.scan_in), 32'h1);
    bus.seed = 4'h8;
    step();
    bus.seed_load = 1'b0;
    chk("seed_8", 32'(bus.lfsr_state), 32'h8);

    // two patterns from 8, ignoring start/seed_load while running
    idx = 14;
    run(2, 1'b1);
    chk("final_6", 32'(bus.lfsr_state), 32'h6);
    chk("scan_in_6", 32'(bus.scan_in), 32'h2);

    // zero pattern count
    bus.start         = 1'b1;
    bus.pattern_count = 16'd0;
    step();
    bus.start = 1'b0;
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_scan_en", 32'(bus.scan_en), 32'd0);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    chk("zero_lfsr", 32'(bus.lfsr_state), 32'h6);
    step();
    chk("zero_done_end", 32'(bus.done), 32'd0);
    chk("zero_lfsr2", 32'(bus.lfsr_state), 32'h6);

    // stop in second SHIFT cycle
    bus.start         = 1'b1;
    bus.pattern_count = 16'd1;
    step();
    bus.start = 1'b0;
    chk("stop_sh1", 32'(bus.lfsr_state), 32'h6);
    step();
    chk("stop_sh2", 32'(bus.lfsr_state), 32'hD);
    chk("stop_sh2_en", 32'(bus.scan_en), 32'd1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_scan_en", 32'(bus.scan_en), 32'd0);
    chk("stop_done", 32'(bus.done), 32'd0);
    chk("stop_lfsr", 32'(bus.lfsr_state), 32'hD);
    step();
    chk("stop_no_done", 32'(bus.done), 32'd0);
    chk("stop_idle_busy", 32'(bus.busy), 32'd0);

    // async reset during CAPTURE
    bus.start         = 1'b1;
    bus.pattern_count = 16'd1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_cap", 32'(bus.capture), 32'd1);
    chk("pre_rst_lfsr", 32'(bus.lfsr_state), 32'hB);
    reset = 1'b0;
    #1;
    chk("arst_capture", 32'(bus.capture), 32'd0);
    chk("arst_lfsr", 32'(bus.lfsr_state), 32'h1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    step();
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_lfsr", 32'(bus.lfsr_state), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
